// File: rtl/fet_cell_checker_if.sv
// Bus between the cell checker, its controller and the cell socket.
// The slave side is the checker; the master side is controller plus CUT socket.
interface fet_cell_checker_if #(
  parameter int unsigned N_INPUTS = 2
);
  logic                start;
  logic [N_INPUTS-1:0] cut_a;
  logic                cut_y;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   err_count;
  logic                fail_valid;
  logic [N_INPUTS-1:0] fail_vec;

  modport slave (
    input  start,
    input  cut_y,
    output cut_a,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_vec
  );

  modport master (
    output start,
    output cut_y,
    input  cut_a,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_vec
  );
endinterface

// File: rtl/fet_cell_checker.sv
// Exhaustive truth-table BIST for a 1..4-input discrete-FET cell.
// Define CELLCHK_STOP_ON_FAIL_EN to end each run at the first mismatching vector.
module fet_cell_checker #(
  parameter int unsigned                N_INPUTS      = 2,
  parameter logic [(2**N_INPUTS)-1:0]   TRUTH_TABLE   = 4'b0111,
  parameter int unsigned                SETTLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  fet_cell_checker_if.slave bus
);

  localparam int unsigned         NVEC        = 2**N_INPUTS;
  localparam logic [N_INPUTS:0]   ERR_MAX     = (N_INPUTS+1)'(NVEC);
  localparam logic [7:0]          SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC    = '1;
`ifdef CELLCHK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_INPUTS-1:0] cut_a_q, cut_a_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic                fail_valid_q, fail_valid_d;
  logic [N_INPUTS-1:0] fail_vec_q, fail_vec_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;

  logic mismatch;
  logic end_run;
  logic busy_o;
  logic done_o;

  // Only the second synchroniser flop is ever compared; cut_y is asynchronous.
  assign mismatch = (sync2_q != TRUTH_TABLE[cut_a_q]);
  assign end_run  = (cut_a_q == LAST_VEC) || (STOP_ON_FAIL && mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cut_a_q      <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cut_a_q      <= cut_a_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = SETTLE;
      SETTLE:     if (cnt_q == '0) state_d = SAMPLE;
      SAMPLE:     state_d = end_run ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cut_a_d      = cut_a_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    sync1_d      = bus.cut_y;
    sync2_d      = sync1_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          cut_a_d      = '0;
          cnt_d        = SETTLE_LOAD;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + (N_INPUTS+1)'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = cut_a_q;
          end
        end
        // On the final (or stopping) vector cut_a is left on the CUT for probing.
        if (!end_run) begin
          cut_a_d = cut_a_q + N_INPUTS'(1);
          cnt_d   = SETTLE_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      SETTLE, SAMPLE: busy_o = 1'b1;
      DONE:           done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.cut_a      = cut_a_q;
  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.pass       = done_o && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule
